// File: rtl/axilrd2wbpipe_if.sv
// AXI-lite read channel plus pipelined Wishbone read bus used by axilrd2wbpipe.
// The master modport is the bridge's view; the slave modport is its environment.
interface axilrd2wbpipe_if #(
  parameter int DW     = 32,
  parameter int ADDR_W = 28
);
  localparam int AW = ADDR_W - $clog2(DW / 8);

  logic              axi_arvalid;
  logic              axi_arready;
  logic [ADDR_W-1:0] axi_araddr;
  logic [2:0]        axi_arprot;

  logic              axi_rvalid;
  logic              axi_rready;
  logic [DW-1:0]     axi_rdata;
  logic [1:0]        axi_rresp;

  logic              wb_cyc;
  logic              wb_stb;
  logic [AW-1:0]     wb_addr;
  logic [DW/8-1:0]   wb_sel;
  logic              wb_stall;
  logic              wb_ack;
  logic              wb_err;
  logic [DW-1:0]     wb_data;

  modport master (
    input  axi_arvalid, axi_araddr, axi_arprot, axi_rready,
           wb_stall, wb_ack, wb_err, wb_data,
    output axi_arready, axi_rvalid, axi_rdata, axi_rresp,
           wb_cyc, wb_stb, wb_addr, wb_sel
  );

  modport slave (
    output axi_arvalid, axi_araddr, axi_arprot, axi_rready,
           wb_stall, wb_ack, wb_err, wb_data,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rresp,
           wb_cyc, wb_stb, wb_addr, wb_sel
  );
endinterface

// File: rtl/axilrd2wbpipe.sv
// AXI-lite read-only slave to pipelined Wishbone master bridge with in-order
// response FIFO, optional abort-on-error and an ack watchdog.
module axilrd2wbpipe #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int LGFIFO           = 3,
  parameter int OPT_TIMEOUT      = 0,
  parameter int OPT_ERR_ABORT    = 1
) (
  input  logic           i_clk,
  input  logic           i_axi_reset_n,
  axilrd2wbpipe_if.master bus
);
  localparam int DW    = C_AXI_DATA_WIDTH;
  localparam int LSB   = $clog2(DW / 8);
  localparam int AW    = C_AXI_ADDR_WIDTH - LSB;
  localparam int CW    = LGFIFO + 1;
  localparam int DEPTH = 1 << LGFIFO;
  localparam int TW    = (OPT_TIMEOUT > 0) ? $clog2(OPT_TIMEOUT + 1) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t            state_q, state_d;
  logic              stb_q, stb_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CW-1:0]     acc_q, acc_d;     // accepted, not yet retired on R
  logic [CW-1:0]     wbo_q, wbo_d;     // strobed on WB, not yet acked
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFIFO-1:0] rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]     wd_q, wd_d;

  logic [DW+1:0]     resp_mem [DEPTH];
  logic [DW+1:0]     push_word;

  logic wb_cyc, wb_issue, wb_ack, wb_err, wb_done;
  logic ar_ready, ar_fire, r_valid, r_fire;
  logic fifo_empty, push, pop;
  logic wd_idle, timeout, abort;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;

  // Acks/errors only count while a cycle is open; err wins over a simultaneous ack.
  assign wb_cyc   = stb_q || (wbo_q != '0);
  assign wb_issue = stb_q && !bus.wb_stall;
  assign wb_ack   = wb_cyc && bus.wb_ack && !bus.wb_err;
  assign wb_err   = wb_cyc && bus.wb_err;
  assign wb_done  = wb_ack || wb_err;

  // acc_q never exceeds DEPTH, so its top bit alone means "full".
  assign ar_ready = (state_q == ST_RUN) && !acc_q[LGFIFO] && (!stb_q || !bus.wb_stall);
  assign ar_fire  = bus.axi_arvalid && ar_ready;

  assign fifo_empty = (fcnt_q == '0);
  assign r_valid    = !fifo_empty || ((state_q == ST_FLUSH) && (acc_q != '0));
  assign r_fire     = r_valid && bus.axi_rready;
  assign push       = wb_done;
  assign pop        = r_fire && !fifo_empty;
  assign push_word  = wb_err ? {{DW{1'b0}}, RESP_SLVERR} : {bus.wb_data, RESP_OKAY};

  generate
    if (OPT_TIMEOUT > 0) begin : g_wd
      assign wd_idle = wb_cyc && (wbo_q != '0) && !wb_done;
      assign timeout = wd_idle && (wd_q == TW'(OPT_TIMEOUT - 1));
    end else begin : g_no_wd
      assign wd_idle = 1'b0;
      assign timeout = 1'b0;
    end
  endgenerate

  assign abort = ((OPT_ERR_ABORT != 0) && wb_err) || timeout;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    stb_d    = stb_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    wbo_d    = wbo_q;
    fcnt_d   = fcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wd_d     = '0;

    if (wb_issue) stb_d = 1'b0;
    if (ar_fire) begin
      stb_d  = 1'b1;
      addr_d = bus.axi_araddr[C_AXI_ADDR_WIDTH-1:LSB];
    end

    unique case ({ar_fire, r_fire})
      2'b10:   acc_d = acc_q + 1'b1;
      2'b01:   acc_d = acc_q - 1'b1;
      default: acc_d = acc_q;
    endcase

    unique case ({wb_issue, wb_done})
      2'b10:   wbo_d = wbo_q + 1'b1;
      2'b01:   wbo_d = wbo_q - 1'b1;
      default: wbo_d = wbo_q;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase

    if (wd_idle) wd_d = wd_q + 1'b1;

    unique case (state_q)
      ST_RUN:   if (abort) state_d = ST_FLUSH;
      ST_FLUSH: if (acc_d == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    // An abort closes the WB cycle; everything still owed is answered by the flush.
    if (abort) begin
      stb_d = 1'b0;
      wbo_d = '0;
      wd_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_axi_reset_n) begin
      state_q  <= ST_RUN;
      stb_q    <= 1'b0;
      addr_q   <= '0;
      acc_q    <= '0;
      wbo_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      wbo_q    <= wbo_d;
      fcnt_q   <= fcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wd_q     <= wd_d;
    end
  end

  // NOTE: the response memory is not reset; fcnt_q guards every read, so stale entries are never visible.
  always_ff @(posedge i_clk) begin
    if (push) resp_mem[wr_ptr_q] <= push_word;
  end

  always_comb begin
    r_data = '0;
    r_resp = RESP_OKAY;
    if (!fifo_empty) begin
      {r_data, r_resp} = resp_mem[rd_ptr_q];
    end else if (state_q == ST_FLUSH) begin
      r_resp = RESP_SLVERR;
    end
  end

  assign bus.axi_arready = ar_ready;
  assign bus.axi_rvalid  = r_valid;
  assign bus.axi_rdata   = r_data;
  assign bus.axi_rresp   = r_resp;
  assign bus.wb_cyc      = wb_cyc;
  assign bus.wb_stb      = stb_q;
  assign bus.wb_addr     = addr_q;
  assign bus.wb_sel      = '1;

  logic unused_inputs;
  assign unused_inputs = ^{bus.axi_arprot, bus.axi_araddr[LSB-1:0]};
endmodule

// File: tb/tb_axilrd2wbpipe.sv
// Bench for axilrd2wbpipe: instance A aborts on error with a 16-cycle watchdog,
// instance B reports per-beat errors; both share stimulus, sel picks the one observed.
module tb_axilrd2wbpipe;
  localparam int DW     = 32;
  localparam int ADDR_W = 28;
  localparam int AW     = 26;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              arvalid = 1'b0, rready = 1'b0, stall = 1'b0;
  logic              ack = 1'b0, err = 1'b0, sel = 1'b0;
  logic [ADDR_W-1:0] araddr = '0;
  logic [DW-1:0]     wdata = '0;

  axilrd2wbpipe_if #(.DW(DW), .ADDR_W(ADDR_W)) bus_a ();
  axilrd2wbpipe_if #(.DW(DW), .ADDR_W(ADDR_W)) bus_b ();

  axilrd2wbpipe #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(ADDR_W), .LGFIFO(3),
                  .OPT_TIMEOUT(16), .OPT_ERR_ABORT(1))
    dut_a (.i_clk(clk), .i_axi_reset_n(rst_n), .bus(bus_a));

  axilrd2wbpipe #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(ADDR_W), .LGFIFO(3),
                  .OPT_TIMEOUT(0), .OPT_ERR_ABORT(0))
    dut_b (.i_clk(clk), .i_axi_reset_n(rst_n), .bus(bus_b));

  assign bus_a.axi_arvalid = arvalid;  assign bus_b.axi_arvalid = arvalid;
  assign bus_a.axi_araddr  = araddr;   assign bus_b.axi_araddr  = araddr;
  assign bus_a.axi_arprot  = 3'b000;   assign bus_b.axi_arprot  = 3'b000;
  assign bus_a.axi_rready  = rready;   assign bus_b.axi_rready  = rready;
  assign bus_a.wb_stall    = stall;    assign bus_b.wb_stall    = stall;
  assign bus_a.wb_ack      = ack;      assign bus_b.wb_ack      = ack;
  assign bus_a.wb_err      = err;      assign bus_b.wb_err      = err;
  assign bus_a.wb_data     = wdata;    assign bus_b.wb_data     = wdata;

  logic          s_arready, s_rvalid, s_cyc, s_stb;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic [AW-1:0] s_wb_addr;
  logic [3:0]    s_wb_sel;
  assign s_arready = sel ? bus_b.axi_arready : bus_a.axi_arready;
  assign s_rvalid  = sel ? bus_b.axi_rvalid  : bus_a.axi_rvalid;
  assign s_rdata   = sel ? bus_b.axi_rdata   : bus_a.axi_rdata;
  assign s_rresp   = sel ? bus_b.axi_rresp   : bus_a.axi_rresp;
  assign s_cyc     = sel ? bus_b.wb_cyc      : bus_a.wb_cyc;
  assign s_stb     = sel ? bus_b.wb_stb      : bus_a.wb_stb;
  assign s_wb_addr = sel ? bus_b.wb_addr     : bus_a.wb_addr;
  assign s_wb_sel  = sel ? bus_b.wb_sel      : bus_a.wb_sel;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rsp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                lat;
    logic [DW-1:0]     data;
    logic [AW-1:0]     wb_addr;
  } vec_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Drive one AR, wait (bounded) for the handshake, record the expected R beat.
  task automatic ar_issue(input logic [ADDR_W-1:0] addr, input logic [AW-1:0] exp_wb,
                          input logic [DW-1:0] d, input logic [1:0] r);
    bit   ok;
    rsp_t e;
    ok = 1'b0;
    arvalid = 1'b1;
    araddr  = addr;
    for (int n = 0; n < 40 && !ok; n++) begin
      #1 ok = s_arready;
      step();
    end
    arvalid = 1'b0;
    check1("ar_accept", ok, 1'b1);
    if (ok) begin
      e.data = d;
      e.resp = r;
      sb.push_back(e);
    end
    check1("stb_after_ar", s_stb, 1'b1);
    checkw("wb_addr", 64'(s_wb_addr), 64'(exp_wb));
  endtask

  task automatic wb_beat(input logic [DW-1:0] d, input bit is_err);
    ack   = !is_err;
    err   = is_err;
    wdata = d;
    step();
    ack   = 1'b0;
    err   = 1'b0;
    wdata = '0;
  endtask

  // Wait (bounded) for rvalid, compare against the scoreboard head, then handshake.
  task automatic r_take();
    bit   ok;
    rsp_t e;
    ok = 1'b0;
    rready = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      #1 ok = s_rvalid;
      if (!ok) step();
    end
    check1("r_valid", ok, 1'b1);
    if (ok) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: got unexpected R beat data 0x%0h resp %b", s_rdata, s_rresp);
      end else begin
        e = sb.pop_front();
        checkw("rdata", 64'(s_rdata), 64'(e.data));
        checkw("rresp", 64'(s_rresp), 64'(e.resp));
      end
      step();
    end
    rready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{addr: 28'h0000040, lat: 2, data: 32'hDEADBEEF, wb_addr: 26'h0000010};
    vecs[1] = '{addr: 28'h0000000, lat: 1, data: 32'h00000000, wb_addr: 26'h0000000};
    vecs[2] = '{addr: 28'hFFFFFFC, lat: 5, data: 32'hFFFFFFFF, wb_addr: 26'h3FFFFFF};
    vecs[3] = '{addr: 28'h1234567, lat: 3, data: 32'h13572468, wb_addr: 26'h048D159};

    // Reset state on both instances.
    rst_n = 1'b0;
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      check1("rst_cyc", s_cyc, 1'b0);
      check1("rst_stb", s_stb, 1'b0);
      check1("rst_rvalid", s_rvalid, 1'b0);
      checkw("rst_rresp", 64'(s_rresp), 64'h0);
    end
    sel = 1'b0;
    rst_n = 1'b1;
    #1 check1("arready_after_rst", s_arready, 1'b1);

    // Table of single reads on instance A.
    for (int i = 0; i < 4; i++) begin
      ar_issue(vecs[i].addr, vecs[i].wb_addr, vecs[i].data, 2'b00);
      checkw("wb_sel", 64'(s_wb_sel), 64'hF);
      check1("wb_cyc_req", s_cyc, 1'b1);
      repeat (vecs[i].lat) step();
      ack = 1'b1;
      wdata = vecs[i].data;
      #1 check1("rvalid_in_ack_cycle", s_rvalid, 1'b0);
      step();
      ack = 1'b0;
      r_take();
      check1("cyc_idle", s_cyc, 1'b0);
      check1("arready_idle", s_arready, 1'b1);
    end

    // Stall holds strobe and address.
    ar_issue(28'h0000080, 26'h0000020, 32'hCAFEF00D, 2'b00);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check1("arready_stalled", s_arready, 1'b0);
      step();
      check1("stb_held", s_stb, 1'b1);
      checkw("addr_held", 64'(s_wb_addr), 64'h20);
    end
    stall = 1'b0;
    #1 check1("arready_unstalled", s_arready, 1'b1);
    step();
    wb_beat(32'hCAFEF00D, 1'b0);
    r_take();

    // Fill to DEPTH on instance B with R held off.
    reset_all();
    sel = 1'b1;
    for (int i = 0; i < 8; i++)
      ar_issue(ADDR_W'(32'h100 + 4 * i), AW'(32'h40 + i), DW'(32'h1000_0000 + i), 2'b00);
    arvalid = 1'b1;
    #1 check1("arready_full", s_arready, 1'b0);
    arvalid = 1'b0;
    for (int i = 0; i < 8; i++) wb_beat(DW'(32'h1000_0000 + i), 1'b0);
    check1("cyc_after_fill_acks", s_cyc, 1'b0);
    rready = 1'b1;
    #1 check1("arready_full_rfire", s_arready, 1'b0);
    r_take();
    check1("arready_after_one_r", s_arready, 1'b1);
    for (int i = 0; i < 7; i++) r_take();

    // Abort on error, instance A.
    reset_all();
    sel = 1'b0;
    ar_issue(28'h0000200, 26'h0000080, 32'hA0000000, 2'b00);
    ar_issue(28'h0000204, 26'h0000081, 32'h0, 2'b10);
    ar_issue(28'h0000208, 26'h0000082, 32'h0, 2'b10);
    ar_issue(28'h000020C, 26'h0000083, 32'h0, 2'b10);
    wb_beat(32'hA0000000, 1'b0);
    wb_beat(32'h0BAD0BAD, 1'b1);
    check1("abort_cyc_low", s_cyc, 1'b0);
    check1("abort_stb_low", s_stb, 1'b0);
    check1("abort_arready", s_arready, 1'b0);
    wb_beat(32'hA0000002, 1'b0);
    wb_beat(32'hA0000003, 1'b0);
    check1("late_ack_cyc", s_cyc, 1'b0);
    for (int i = 0; i < 3; i++) r_take();
    check1("flush_arready_held", s_arready, 1'b0);
    r_take();
    check1("flush_done_arready", s_arready, 1'b1);

    // Per-beat error, instance B.
    reset_all();
    sel = 1'b1;
    ar_issue(28'h0000300, 26'h00000C0, 32'hB0000000, 2'b00);
    ar_issue(28'h0000304, 26'h00000C1, 32'h0, 2'b10);
    ar_issue(28'h0000308, 26'h00000C2, 32'hB0000002, 2'b00);
    ar_issue(28'h000030C, 26'h00000C3, 32'hB0000003, 2'b00);
    wb_beat(32'hB0000000, 1'b0);
    wb_beat(32'h0BAD0BAD, 1'b1);
    check1("noabort_cyc_high", s_cyc, 1'b1);
    check1("noabort_arready", s_arready, 1'b1);
    wb_beat(32'hB0000002, 1'b0);
    wb_beat(32'hB0000003, 1'b0);
    check1("noabort_cyc_done", s_cyc, 1'b0);
    for (int i = 0; i < 4; i++) r_take();

    // Watchdog on instance A: abort after the 16th idle cycle.
    reset_all();
    sel = 1'b0;
    ar_issue(28'h0000400, 26'h0000100, 32'h0, 2'b10);
    for (int i = 1; i <= 17; i++) begin
      step();
      check1("wd_cyc", s_cyc, i < 17);
    end
    check1("wd_arready_flush", s_arready, 1'b0);
    r_take();
    check1("wd_arready_after", s_arready, 1'b1);

    // Reset mid-transaction on instance A.
    reset_all();
    sel = 1'b0;
    ar_issue(28'h0000500, 26'h0000140, 32'hC0000000, 2'b00);
    ar_issue(28'h0000504, 26'h0000141, 32'hC0000001, 2'b00);
    ar_issue(28'h0000508, 26'h0000142, 32'hC0000002, 2'b00);
    wb_beat(32'hC0000000, 1'b0);
    check1("pre_rst_rvalid", s_rvalid, 1'b1);
    rst_n = 1'b0;
    step();
    check1("midrst_cyc", s_cyc, 1'b0);
    check1("midrst_rvalid", s_rvalid, 1'b0);
    check1("midrst_stb", s_stb, 1'b0);
    rst_n = 1'b1;
    sb.delete();
    #1 check1("midrst_arready", s_arready, 1'b1);
    wb_beat(32'hDDDDDDDD, 1'b0);
    check1("late_ack_rvalid", s_rvalid, 1'b0);
    check1("late_ack_cyc_low", s_cyc, 1'b0);
    ar_issue(28'h0000044, 26'h0000011, 32'h600DF00D, 2'b00);
    step();
    wb_beat(32'h600DF00D, 1'b0);
    r_take();
    checkw("sb_drained", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axilrd2wbpipe.md
AXILRD2WBPIPE -- requirements
Module: axilrd2wbpipe

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, AXI/WB data width (DW); legal values 32, 64, 128.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 28, AXI byte-address width.
REQ-003 SHALL have parameter LGFIFO, default 3, log2 of max requests in flight (DEPTH=2^LGFIFO); legal range 1..6.
REQ-004 SHALL have parameter OPT_TIMEOUT, default 0, WB ack-watchdog limit in cycles; 0 disables the watchdog.
REQ-005 SHALL have parameter OPT_ERR_ABORT, default 1; 1 = abort cycle on WB error; 0 = per-beat error, cycle continues.
REQ-006 SHALL derive localparam AW = C_AXI_ADDR_WIDTH - log2(DW/8), the WB word-address width.
REQ-007 i_clk  in  1  sole clock; all logic rising-edge.
REQ-008 i_axi_reset_n  in  1  reset; synchronous and active-low.
REQ-009 i_axi_arvalid in 1, o_axi_arready out 1, i_axi_araddr in C_AXI_ADDR_WIDTH, i_axi_arprot in 3 (ignored): AXI-lite read address channel.
REQ-010 o_axi_rvalid out 1, i_axi_rready in 1, o_axi_rdata out DW, o_axi_rresp out 2: AXI-lite read data channel.
REQ-011 o_wb_cyc, o_wb_stb out 1; o_wb_addr out AW; o_wb_sel out DW/8; i_wb_stall, i_wb_ack, i_wb_err in 1; i_wb_data in DW: pipelined WB master, read-only.

Function
REQ-012 SHALL drive o_wb_addr = i_axi_araddr[C_AXI_ADDR_WIDTH-1:log2(DW/8)] and o_wb_sel = all ones on every request.
REQ-013 SHALL compute o_axi_arready combinationally = !flushing && (accepted-not-retired < DEPTH) && (!o_wb_stb || !i_wb_stall).
REQ-014 AR handshake in cycle n SHALL present o_wb_stb=1 with that address in cycle n+1; back-to-back accepts issue one strobe per cycle when not stalled.
REQ-015 o_wb_stb SHALL hold with stable address while i_wb_stall=1.
REQ-016 o_wb_cyc SHALL be high while o_wb_stb=1 or WB-outstanding > 0, and low otherwise.
REQ-017 WB-outstanding counter SHALL increment on stb&&!stall, decrement on ack or err, both on the same cycle = no change; width LGFIFO+1.
REQ-018 i_wb_ack/i_wb_err SHALL be ignored while o_wb_cyc=0.
REQ-019 Each ack at cycle m SHALL write {i_wb_data, OKAY} into a DEPTH-entry response FIFO; o_axi_rvalid for it SHALL be asserted no earlier than m+1.
REQ-020 Responses SHALL be returned in request order; o_axi_rdata/o_axi_rresp SHALL be stable while o_axi_rvalid && !i_axi_rready.
REQ-021 OPT_ERR_ABORT=0: err SHALL write {0, SLVERR(2'b10)} for that beat only; cycle and later requests continue normally.
REQ-022 OPT_ERR_ABORT=1: err SHALL write {0, SLVERR} for that beat, drop o_wb_cyc and o_wb_stb next cycle, and enter flushing.
REQ-023 Flushing SHALL return SLVERR, rdata 0, for every accepted request not yet acked, in order, one per R handshake; flushing SHALL clear when accepted-not-retired reaches 0.
REQ-024 Watchdog (OPT_TIMEOUT>0) SHALL count cycles with o_wb_cyc=1, WB-outstanding>0 and no ack/err; counter clears on any ack/err or when cyc is low.
REQ-025 Watchdog reaching OPT_TIMEOUT SHALL abort exactly as REQ-022 regardless of OPT_ERR_ABORT, the timed-out beat reported SLVERR.
REQ-026 Ack and err in the same cycle SHALL be treated as err.
REQ-027 Accepted-not-retired count SHALL never exceed DEPTH; at DEPTH o_axi_arready=0 even if an R handshake occurs that cycle.

Reset
REQ-028 While i_axi_reset_n=0 at a clock edge: o_wb_cyc=0, o_wb_stb=0, o_axi_rvalid=0, o_axi_rresp=0, all counters/pointers 0, flushing=0, watchdog=0.
REQ-029 Reset mid-transaction SHALL discard all outstanding state; acks arriving after reset SHALL be ignored (cyc low); o_axi_arready=1 the first cycle after reset release.

Verification
REQ-030 Single read: araddr 0x40, WB ack after 2 cycles with data 0xDEADBEEF -> o_wb_addr=0x10, rdata 0xDEADBEEF, rresp 00.
REQ-031 Fill: 8 back-to-back ARs, rready=0, LGFIFO=3 -> 8 strobes, arready=0 after 8th; one R handshake -> arready returns 1.
REQ-032 OPT_ERR_ABORT=1, 4 outstanding, err on 2nd -> rresp 00,10,10,10; cyc low one cycle after err; arready 0 until last retired.
REQ-033 OPT_ERR_ABORT=0, same stimulus, acks on 3rd/4th -> rresp 00,10,00,00 with data on beats 3,4; cyc stays high.
REQ-034 OPT_TIMEOUT=16, no ack -> abort at 16th idle cycle, single SLVERR response, arready 1 after retire.
REQ-035 Reset asserted with 3 outstanding and rvalid=1 -> next cycle cyc=0, rvalid=0; late ack ignored; fresh read then completes OKAY.
